// File: rtl/ms_delay_ctrl_pkg.sv
// ms_delay_ctrl_pkg
//   Shared definitions for the millisecond delay controller: the default
//   counter width and the FSM state encoding. The encoding is fixed because
//   the state is exported on a debug port and decoded by external checkers.
package ms_delay_ctrl_pkg;

  // Default width of the delay request and elapsed counter (max 65535 ms).
  localparam int DEF_CNT_W = 16;

  // Fixed state encoding.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_LOAD = S_LOAD,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE
  } state_e;

endpackage : ms_delay_ctrl_pkg

// File: rtl/ms_delay_ctrl.sv
// ms_delay_ctrl
//   Initiator/consumer for the LFSR 1 ms timer. Accepts a delay request in
//   milliseconds, clears the timer for one cycle, enables it and counts its
//   1 ms timeout pulses until the requested delay has elapsed, then emits a
//   one-cycle done pulse.
//
// Ports
//   clk        in   system clock (50 MHz)
//   rst        in   synchronous, active-low reset
//   start      in   request pulse, sampled only in IDLE
//   delay_ms   in   requested delay in ms, captured on the accepted start
//   abort      in   cancels an active delay (LOAD or RUN)
//   tick       in   1 ms timeout pulse from the timer, one cycle wide
//   tmr_rst_n  out  active-low clear to the timer
//   tmr_en     out  enable to the timer
//   busy       out  high while a delay is in progress
//   done       out  one-cycle completion pulse
//   elapsed    out  ms ticks counted in the current or most recent delay
//   state_dbg  out  current FSM state (S_IDLE/S_LOAD/S_RUN/S_DONE)
//
// Request/completion handshake:
//   start acts as a valid with an implicit ready of "busy==0 && done==0"
//   (state IDLE). A start presented while the block is not in IDLE is
//   dropped, not queued. Every accepted start ends in exactly one of: a
//   single-cycle done pulse (delay ran out, or delay_ms==0), an abort (no
//   done), or a reset (no done). The earliest start that can be accepted
//   after a done is in the cycle following the done pulse.
module ms_delay_ctrl
  import ms_delay_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] delay_ms,
  input  logic             abort,
  input  logic             tick,
  output logic             tmr_rst_n,
  output logic             tmr_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] elapsed,
  output logic [1:0]       state_dbg
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] elapsed_q, elapsed_d;
  logic [CNT_W-1:0] elapsed_inc;
  logic             tmr_rst_n_q, tmr_rst_n_d;
  logic             tmr_en_q, tmr_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  assign elapsed_inc = elapsed_q + CNT_W'(1);

  // Next-state, counter and target logic.
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    elapsed_d = elapsed_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          elapsed_d = '0;
          if (delay_ms != '0) begin
            target_d = delay_ms;
            state_d  = ST_LOAD;
          end else begin
            // Zero delay completes immediately without touching the timer.
            state_d = ST_DONE;
          end
        end
      end
      ST_LOAD: begin
        if (abort) state_d = ST_IDLE;
        else       state_d = ST_RUN;
      end
      ST_RUN: begin
        // Abort wins over a same-cycle final tick; the count is frozen.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          elapsed_d = elapsed_inc;
          if (elapsed_inc == target_q) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state and registered, so each
    // output changes on the same edge as the state it belongs to.
    // Holding the timer in clear during LOAD guarantees the first interval
    // counted in RUN is a full millisecond.
    tmr_rst_n_d = (state_d != ST_LOAD);
    tmr_en_d    = (state_d == ST_RUN);
    busy_d      = (state_d == ST_LOAD) || (state_d == ST_RUN);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      target_q    <= '0;
      elapsed_q   <= '0;
      tmr_rst_n_q <= 1'b0;
      tmr_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      elapsed_q   <= elapsed_d;
      tmr_rst_n_q <= tmr_rst_n_d;
      tmr_en_q    <= tmr_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign tmr_rst_n = tmr_rst_n_q;
  assign tmr_en    = tmr_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign elapsed   = elapsed_q;
  assign state_dbg = state_q;

endmodule : ms_delay_ctrl

// File: tb/tb_ms_delay_ctrl.sv
// tb_ms_delay_ctrl
//   Self-checking bench for ms_delay_ctrl. Each delay request is driven as a
//   transaction; expected outputs are derived from the request (delay,
//   number of ticks delivered, abort point) and every done pulse is matched
//   against a queue of expected final elapsed values.
module tb_ms_delay_ctrl;
  import ms_delay_ctrl_pkg::*;

  localparam int W = DEF_CNT_W;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] delay_ms = '0;
  logic         abort = 1'b0;
  logic         tick = 1'b0;
  logic         tmr_rst_n, tmr_en, busy, done;
  logic [W-1:0] elapsed;
  logic [1:0]   state_dbg;

  always #10 clk = ~clk;

  ms_delay_ctrl #(.CNT_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .delay_ms  (delay_ms),
    .abort     (abort),
    .tick      (tick),
    .tmr_rst_n (tmr_rst_n),
    .tmr_en    (tmr_en),
    .busy      (busy),
    .done      (done),
    .elapsed   (elapsed),
    .state_dbg (state_dbg)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int e_busy, input int e_en,
                            input int e_rstn, input int e_done, input int e_elapsed);
    check_eq({tag, ".busy"},      32'(busy),      32'(e_busy));
    check_eq({tag, ".tmr_en"},    32'(tmr_en),    32'(e_en));
    check_eq({tag, ".tmr_rst_n"}, 32'(tmr_rst_n), 32'(e_rstn));
    check_eq({tag, ".done"},      32'(done),      32'(e_done));
    check_eq({tag, ".elapsed"},   32'(elapsed),   32'(e_elapsed));
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           done_seen = 0;
  int           done_expected = 0;

  always @(negedge clk) begin
    if (rst && done === 1'b1) begin
      done_seen++;
      check_eq("sb_done_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check_eq("sb_elapsed", 32'(elapsed), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs are driven after a falling edge; outputs are sampled after the
  // next falling edge, so they reflect the rising edge that saw the inputs.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  int last_elapsed = 0;

  // mode 0: run to completion
  // mode 1: abort after abort_m ticks (abort_m < d)
  // mode 2: abort coincident with the final tick
  // mode 3: abort during the timer-clear cycle
  task automatic run_delay(input int d, input int gap, input int mode, input int abort_m);
    string tg;
    int    n_ticks;
    tg = $sformatf("d%0d_m%0d", d, mode);
    start    = 1'b1;
    delay_ms = W'(d);
    if (d == 0) begin
      exp_q.push_back('0);
      done_expected++;
    end
    step();
    start    = 1'b0;
    delay_ms = W'($urandom);
    if (d == 0) begin
      check_outs({tg, ".zero"}, 0, 0, 1, 1, 0);
      // start in the done cycle must be dropped
      start    = 1'b1;
      delay_ms = W'(7);
      step();
      start = 1'b0;
      check_outs({tg, ".zero_after"}, 0, 0, 1, 0, 0);
      last_elapsed = 0;
      return;
    end
    check_outs({tg, ".load"}, 1, 0, 0, 0, 0);
    tick = 1'($urandom_range(0, 1));  // ticks during the clear cycle are ignored
    if (mode == 3) abort = 1'b1;
    step();
    tick  = 1'b0;
    abort = 1'b0;
    if (mode == 3) begin
      check_outs({tg, ".abort_load"}, 0, 0, 1, 0, 0);
      last_elapsed = 0;
      return;
    end
    check_outs({tg, ".run"}, 1, 1, 1, 0, 0);

    n_ticks = (mode == 1) ? abort_m : d;
    for (int t = 1; t <= n_ticks; t++) begin
      for (int g = 1; g < gap; g++) begin
        start    = ($urandom_range(0, 3) == 0);
        delay_ms = W'($urandom_range(1, 20));
        step();
        start = 1'b0;
        check_eq({tg, ".gap_elapsed"}, 32'(elapsed), 32'(t - 1));
        check_eq({tg, ".gap_busy"},    32'(busy),    32'd1);
      end
      tick = 1'b1;
      if (mode == 2 && t == d) abort = 1'b1;
      if (mode == 0 && t == d) begin
        exp_q.push_back(W'(d));
        done_expected++;
      end
      step();
      tick  = 1'b0;
      abort = 1'b0;
      if (mode == 0 && t == d) begin
        check_outs({tg, ".done"}, 0, 0, 1, 1, d);
        start    = 1'b1;
        delay_ms = W'(9);
        step();
        start = 1'b0;
        check_outs({tg, ".after_done"}, 0, 0, 1, 0, d);
        last_elapsed = d;
      end else if (mode == 2 && t == d) begin
        check_outs({tg, ".abort_final"}, 0, 0, 1, 0, d - 1);
        last_elapsed = d - 1;
      end else begin
        check_outs({tg, $sformatf(".tick%0d", t)}, 1, 1, 1, 0, t);
      end
    end

    if (mode == 1) begin
      abort = 1'b1;
      step();
      abort = 1'b0;
      check_outs({tg, ".abort_run"}, 0, 0, 1, 0, abort_m);
      last_elapsed = abort_m;
    end
  endtask

  // Stray tick and abort while idle must not disturb anything.
  task automatic idle_noise();
    tick  = 1'b1;
    abort = 1'($urandom_range(0, 1));
    step();
    tick  = 1'b0;
    abort = 1'b0;
    check_outs("idle_noise", 0, 0, 1, 0, last_elapsed);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d, gap, mode, am;
    rst = 1'b0;
    repeat (3) step();
    check_outs("reset", 0, 0, 0, 0, 0);
    check_eq("reset.state", 32'(state_dbg), 32'(S_IDLE));
    rst = 1'b1;
    step();
    check_outs("reset_release", 0, 0, 1, 0, 0);

    // directed cases
    run_delay(3, 10, 0, 0);
    idle_noise();
    run_delay(0, 1, 0, 0);
    run_delay(5, 10, 1, 2);
    idle_noise();
    run_delay(5, 10, 2, 0);
    run_delay(2, 4, 0, 0);
    run_delay(4, 3, 3, 0);
    run_delay(1, 1, 0, 0);
    idle_noise();

    // randomized transactions
    for (int i = 0; i < 30; i++) begin
      d    = $urandom_range(0, 6);
      gap  = $urandom_range(1, 5);
      mode = $urandom_range(0, 3);
      am   = 0;
      if (mode == 1) begin
        if (d < 1) mode = 0;
        else am = $urandom_range(0, d - 1);
      end
      run_delay(d, gap, mode, am);
      if ($urandom_range(0, 1) == 1) idle_noise();
    end

    // reset in the middle of a run clears everything, timer included
    start    = 1'b1;
    delay_ms = W'(4);
    step();
    start = 1'b0;
    step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    check_outs("pre_reset_run", 1, 1, 1, 0, 1);
    rst = 1'b0;
    step();
    check_outs("mid_run_reset", 0, 0, 0, 0, 0);
    check_eq("mid_run_reset.state", 32'(state_dbg), 32'(S_IDLE));
    rst = 1'b1;
    step();
    check_outs("mid_run_release", 0, 0, 1, 0, 0);
    repeat (2) step();

    check_eq("sb_queue_empty", 32'(exp_q.size()), 32'd0);
    check_eq("sb_done_count", 32'(done_seen), 32'(done_expected));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_ms_delay_ctrl
